// File: rtl/sm_divider_if.sv
// Handshake and operand/result bundle for the sign-magnitude divider.
interface sm_divider_if;
    logic       start;
    logic [8:0] dividend;
    logic [4:0] divisor;
    logic [8:0] quot;
    logic [4:0] rem;
    logic       busy;
    logic       done;
    logic       dbz;

    modport master (output start, dividend, divisor,
                    input  quot, rem, busy, done, dbz);
    modport slave  (input  start, dividend, divisor,
                    output quot, rem, busy, done, dbz);
endinterface

// File: rtl/sm_divider.sv
// Sequential restoring divider for 9-bit / 5-bit sign-magnitude operands.
// Optional macro SM_DIVIDER_DBZ_EN: short-circuit divide-by-zero with a dbz flag.
module sm_divider (
    input  logic         clk,
    input  logic         rst,
    sm_divider_if.slave  bus
);
    localparam int unsigned DVD_W = 8;
    localparam int unsigned DVS_W = 4;
    localparam int unsigned CNT_W = 3;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DVD_W-1:0] dvd_q, dvd_d;
    logic [DVS_W:0]   prem_q, prem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic             qsign_q, qsign_d;
    logic             rsign_q, rsign_d;
    logic [DVD_W:0]   quot_q, quot_d;
    logic [DVS_W:0]   rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [DVS_W:0]   shifted;
    logic [DVS_W+1:0] diff;
    logic             qbit;
    logic             accept;
    logic             dbz_hit;
    logic [DVD_W-1:0] qmag;
    logic [DVS_W-1:0] rmag;

    // One restoring step: shift in next dividend bit, trial-subtract the divisor.
    always_comb begin
        shifted = {prem_q[DVS_W-1:0], dvd_q[DVD_W-1]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
        qbit    = ~diff[DVS_W+1];
        qmag    = {dvd_q[DVD_W-2:0], qbit};
        rmag    = (dvs_q == '0) ? '0 : (qbit ? diff[DVS_W-1:0] : shifted[DVS_W-1:0]);
        accept  = bus.start && ((state_q == S_IDLE) || (state_q == S_DONE));
`ifdef SM_DIVIDER_DBZ_EN
        dbz_hit = (dvs_q == '0);
`else
        dbz_hit = 1'b0;
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dvd_d   = dvd_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        qsign_d = qsign_q;
        rsign_d = rsign_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_CALC: begin
                if (dbz_hit) begin
                    state_d = S_DONE;
                    quot_d  = '0;
                    rem_d   = '0;
                    dbz_d   = 1'b1;
                end else begin
                    prem_d = qbit ? diff[DVS_W:0] : shifted;
                    dvd_d  = qmag;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(DVD_W - 1)) begin
                        state_d = S_DONE;
                        quot_d  = {qsign_q & (|qmag), qmag};
                        rem_d   = {rsign_q & (|rmag), rmag};
                        dbz_d   = 1'b0;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Negative-zero operands contribute no sign to the quotient.
        if (accept) begin
            state_d = S_CALC;
            cnt_d   = '0;
            prem_d  = '0;
            dvd_d   = bus.dividend[DVD_W-1:0];
            dvs_d   = bus.divisor[DVS_W-1:0];
            qsign_d = (bus.dividend[DVD_W] & (|bus.dividend[DVD_W-1:0]))
                    ^ (bus.divisor[DVS_W] & (|bus.divisor[DVS_W-1:0]));
            rsign_d = bus.dividend[DVD_W];
        end

        busy_d = (state_d == S_CALC);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dvd_q   <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            qsign_q <= 1'b0;
            rsign_q <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dvd_q   <= dvd_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            qsign_q <= qsign_d;
            rsign_q <= rsign_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.quot = quot_q;
    assign bus.rem  = rem_q;
    assign bus.dbz  = dbz_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_sm_divider.sv
// Directed-vector bench for sm_divider; expected results computed by hand.
module tb_sm_divider;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    sm_divider_if bus ();

    sm_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge, then count edges until done (-1 on timeout).
    task automatic run_op(input logic [8:0] dvd, input logic [4:0] dvs, output int lat);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        tick();
        bus.start = 1'b0;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        #3;
        vectors++;
        if ({bus.quot, bus.rem, bus.busy, bus.done, bus.dbz} !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_state: got q=%h r=%h busy=%b done=%b dbz=%b, want all zero",
                     bus.quot, bus.rem, bus.busy, bus.done, bus.dbz);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [8:0] t_dvd [9];
        logic [4:0] t_dvs [9];
        logic [8:0] t_q   [9];
        logic [4:0] t_r   [9];
        int lat;
        t_dvd = '{9'h064, 9'h164, 9'h009, 9'h100, 9'h0FF, 9'h1FF, 9'h007, 9'h107, 9'h0C8};
        t_dvs = '{5'h07,  5'h07,  5'h13,  5'h05,  5'h01,  5'h0F,  5'h19,  5'h09,  5'h1D};
        t_q   = '{9'h00E, 9'h10E, 9'h103, 9'h000, 9'h0FF, 9'h111, 9'h000, 9'h000, 9'h10F};
        t_r   = '{5'h02,  5'h12,  5'h00,  5'h00,  5'h00,  5'h00,  5'h07,  5'h17,  5'h05};
        for (int k = 0; k < 9; k++) begin
            run_op(t_dvd[k], t_dvs[k], lat);
            vectors++;
            if (lat !== 8) begin
                miscompares++;
                $display("FAIL basic_latency[%0d]: got %0d edges after start edge, want 8", k, lat);
            end
            vectors++;
            if (bus.quot !== t_q[k] || bus.rem !== t_r[k] || bus.dbz !== 1'b0) begin
                miscompares++;
                $display("FAIL basic_result[%0d] %h/%h: got q=%h r=%h dbz=%b, want q=%h r=%h dbz=0",
                         k, t_dvd[k], t_dvs[k], bus.quot, bus.rem, bus.dbz, t_q[k], t_r[k]);
            end
            tick();
        end
    endtask

    task automatic test_zero_div();
        logic [4:0] z_dvs [2];
        logic [8:0] z_dvd [2];
        logic [8:0] exp_q [2];
        int exp_lat;
        logic exp_dbz;
        int lat;
        z_dvd = '{9'h064, 9'h164};
        z_dvs = '{5'h10,  5'h00};
`ifdef SM_DIVIDER_DBZ_EN
        exp_lat = 1;
        exp_dbz = 1'b1;
        exp_q   = '{9'h000, 9'h000};
`else
        exp_lat = 8;
        exp_dbz = 1'b0;
        exp_q   = '{9'h0FF, 9'h1FF};
`endif
        for (int k = 0; k < 2; k++) begin
            run_op(z_dvd[k], z_dvs[k], lat);
            vectors++;
            if (lat !== exp_lat) begin
                miscompares++;
                $display("FAIL zero_div_latency[%0d]: got %0d, want %0d", k, lat, exp_lat);
            end
            vectors++;
            if (bus.quot !== exp_q[k] || bus.rem !== 5'h00 || bus.dbz !== exp_dbz) begin
                miscompares++;
                $display("FAIL zero_div_result[%0d]: got q=%h r=%h dbz=%b, want q=%h r=00 dbz=%b",
                         k, bus.quot, bus.rem, bus.dbz, exp_q[k], exp_dbz);
            end
            tick();
        end
    endtask

    task automatic test_ignore_start();
        int done_cnt;
        int first;
        bus.start    = 1'b1;
        bus.dividend = 9'h064;
        bus.divisor  = 5'h07;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        bus.start    = 1'b1;
        bus.dividend = 9'h0FF;
        bus.divisor  = 5'h01;
        tick();
        bus.start = 1'b0;
        done_cnt  = 0;
        first     = -1;
        for (int i = 4; i <= 20; i++) begin
            tick();
            if (bus.done) begin
                done_cnt++;
                if (first < 0) first = i;
            end
        end
        vectors++;
        if (done_cnt !== 1 || first !== 8) begin
            miscompares++;
            $display("FAIL ignore_start_done: got %0d pulses first at edge %0d, want 1 at edge 8",
                     done_cnt, first);
        end
        vectors++;
        if (bus.quot !== 9'h00E || bus.rem !== 5'h02) begin
            miscompares++;
            $display("FAIL ignore_start_result: got q=%h r=%h, want q=00e r=02", bus.quot, bus.rem);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        bus.start    = 1'b1;
        bus.dividend = 9'h064;
        bus.divisor  = 5'h07;
        tick();
        bus.dividend = 9'h164;
        bus.divisor  = 5'h13;
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        vectors++;
        if (lat !== 8 || bus.quot !== 9'h00E || bus.rem !== 5'h02) begin
            miscompares++;
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want lat=8 q=00e r=02",
                     lat, bus.quot, bus.rem);
        end
        tick();
        bus.start = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
        end
        lat = -1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        vectors++;
        if (lat !== 8 || bus.quot !== 9'h021 || bus.rem !== 5'h11) begin
            miscompares++;
            $display("FAIL b2b_second: got lat=%0d q=%h r=%h, want lat=8 q=021 r=11",
                     lat, bus.quot, bus.rem);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int done_seen;
        int lat;
        bus.start    = 1'b1;
        bus.dividend = 9'h0FF;
        bus.divisor  = 5'h01;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) tick();
        rst = 1'b1;
        #1;
        vectors++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.quot !== 9'h000 || bus.rem !== 5'h00) begin
            miscompares++;
            $display("FAIL reset_mid_async: got busy=%b done=%b q=%h r=%h, want all zero",
                     bus.busy, bus.done, bus.quot, bus.rem);
        end
        tick();
        rst = 1'b0;
        done_seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) done_seen++;
        end
        vectors++;
        if (done_seen !== 0) begin
            miscompares++;
            $display("FAIL reset_mid_abort: got %0d busy/done cycles after reset, want 0", done_seen);
        end
        run_op(9'h064, 5'h07, lat);
        vectors++;
        if (lat !== 8 || bus.quot !== 9'h00E || bus.rem !== 5'h02 || bus.dbz !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_restart: got lat=%0d q=%h r=%h dbz=%b, want lat=8 q=00e r=02 dbz=0",
                     lat, bus.quot, bus.rem, bus.dbz);
        end
        tick();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_zero_div();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sm_divider.md
SM_DIVIDER -- requirements
Module: sm_divider

Interface
REQ-001 Parameters: none; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request; sampled only while busy=0.
REQ-005 dividend  input  9  sign-magnitude: [8] sign (1=negative), [7:0] magnitude.
REQ-006 divisor  input  5  sign-magnitude: [4] sign, [3:0] magnitude.
REQ-007 quot  output  9  sign-magnitude quotient, registered.
REQ-008 rem  output  5  sign-magnitude remainder, registered.
REQ-009 busy  output  1  high while an operation is in progress.
REQ-010 done  output  1  one-cycle completion pulse; quot/rem/dbz valid from this cycle.
REQ-011 dbz  output  1  divide-by-zero flag, registered with quot/rem.

Function
REQ-012 States SHALL be IDLE, CALC, DONE; IDLE -> CALC on an accepted start; CALC -> DONE after 8 iterations; DONE -> IDLE on the next edge unless start is accepted.
REQ-013 start SHALL be accepted at a rising edge when the state is IDLE or DONE; dividend and divisor SHALL be latched at that edge.
REQ-014 start while busy=1 SHALL be ignored and SHALL NOT disturb the operation in progress or the latched operands.
REQ-015 busy SHALL be 1 in CALC only; done SHALL be 1 in DONE only.
REQ-016 Latency: start accepted at edge E0; CALC performs one restoring shift-subtract iteration per edge E1..E8, MSB of magnitude first; done=1 in the cycle following E8.
REQ-017 Partial remainder SHALL be 5 bits wide; each iteration: shift in the next dividend bit, subtract divisor magnitude, keep the result and set the quotient bit if the result is non-negative, else restore.
REQ-018 quot[7:0] = floor(|dividend| / |divisor|), rem[3:0] = |dividend| mod |divisor|, rem width 4 bits of magnitude.
REQ-019 quot[8] SHALL equal dividend[8] XOR divisor[4], forced to 0 when quot[7:0]=0.
REQ-020 rem[4] SHALL equal dividend[8], forced to 0 when rem[3:0]=0.
REQ-021 quot, rem and dbz SHALL update only at the edge entering DONE and SHALL hold until the next completion.
REQ-022 Negative-zero operands (magnitude 0, sign 1) SHALL be treated as zero.

Reset
REQ-023 rst=1 SHALL immediately force state IDLE, quot=9'h000, rem=5'h00, busy=0, done=0, dbz=0, independent of clk.
REQ-024 Reset asserted mid-operation SHALL abort it without a done pulse; the first start after release SHALL be accepted normally.

Configuration
REQ-025 Macro SM_DIVIDER_DBZ_EN: when defined, an accepted start with divisor[3:0]=0 SHALL go directly to DONE at E1 with quot=9'h000, rem=5'h00, dbz=1.
REQ-026 When SM_DIVIDER_DBZ_EN is not defined, dbz SHALL be tied 0 and a zero divisor SHALL take the normal 8-iteration path, yielding quot={sign per REQ-019, 8'hFF}, rem=5'h00.

Verification
REQ-027 dividend=9'h064 (+100), divisor=5'h07 -> done exactly 9 edges after start, quot=9'h00E, rem=5'h02, dbz=0.
REQ-028 dividend=9'h164 (-100), divisor=5'h07 -> quot=9'h10E, rem=5'h12; dividend=9'h009, divisor=5'h13 (-3) -> quot=9'h103, rem=5'h00.
REQ-029 dividend=9'h100 (-0), divisor=5'h05 -> quot=9'h000, rem=5'h00 (no negative zero).
REQ-030 Divisor=5'h10 with macro -> done at E1, dbz=1, quot=0, rem=0; without macro -> done after 9 edges, quot=9'h0FF (for positive dividend), dbz=0.
REQ-031 Second start pulsed with new operands at E3 of an operation -> first result unchanged, no extra done; start held high through DONE -> back-to-back operation accepted at the DONE edge.
REQ-032 rst pulsed at E4 of an operation -> busy=0, done never asserted, outputs zero; a subsequent start completes correctly.
